// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x-free mid-bit sampling) feeding a first-word-fall-through byte FIFO.
// Good bytes are pushed at the stop-bit sample; framing errors and full-FIFO drops pulse for one cycle.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  output logic [7:0]                   data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         frame_error,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int PTR_W            = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic             sync_p0, sync_p1;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             stop_good, stop_bad;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, push, full;

  // Stage p0/p1: two-flop synchronizer, idles high like the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= serial_in;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
    end
  end

  // The shift register is never pushed before eight fresh samples, so it needs no reset
  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    stop_good    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (!sync_p1) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_SAMPLE && sync_p1) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = DATA;
          cnt_next     = '0;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_SAMPLE) shift_next = {sync_p1, shift[7:1]};
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at the mid-bit sample so a back-to-back start edge is never missed
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_SAMPLE) begin
          state_next = IDLE;
          cnt_next   = '0;
          stop_good  = sync_p1;
          stop_bad   = !sync_p1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_out_valid = (fifo_count != '0);
  assign data_out       = mem[rd_ptr];
  assign pop            = data_out_valid && data_out_ready;
  assign full           = (fifo_count == COUNT_FULL);
  assign push           = stop_good && (!full || pop);

  // Stage p2: FIFO update and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      frame_error <= stop_bad;
      overflow    <= stop_good && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: bit-level serial driver, queue-based FIFO model and pulse counters.
module tb_uart_rx_fifo;

  localparam int N     = 50_000_000 / 115_200;
  localparam int S     = N / 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_error;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int ovf_seen = 0;
  int exp_ferr = 0;
  int exp_ovf = 0;
  logic [7:0] model_q[$];

  always #10 clk = ~clk;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .frame_error   (frame_error),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  // Each pulse is high for whole cycles, so one count per cycle high
  always @(negedge clk) begin
    if (frame_error) ferr_seen++;
    if (overflow)    ovf_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one completed frame
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)                    exp_ferr++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else                             exp_ovf++;
  endtask

  // Drives a full 10-bit frame starting at a falling clock edge. The receiver
  // samples the stop bit on the (S+4)-th rising edge after the stop bit is driven.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input bit pop_at_stop, input bit timing_chk);
    serial_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (N) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (S + 3) @(posedge clk);
    @(negedge clk);
    if (timing_chk)
      check("valid_before_stop_sample", 32'(data_out_valid), 32'(model_q.size() != 0));
    if (pop_at_stop) begin
      check("head_at_pop", 32'(data_out), 32'(model_q[0]));
      data_out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (pop_at_stop) begin
      data_out_ready = 1'b0;
      void'(model_q.pop_front());
    end
    model_frame(b, stop_bit);
    if (timing_chk) begin
      check("valid_after_stop_sample", 32'(data_out_valid), 32'(model_q.size() != 0));
      check("count_after_stop_sample", 32'(fifo_count), 32'(model_q.size()));
    end
    serial_in = 1'b1;
    repeat (N - S - 4) @(negedge clk);
    // A low stop bit looks like a start edge; let that false start be rejected
    if (!stop_bit) repeat (N) @(negedge clk);
  endtask

  task automatic drain();
    data_out_ready = 1'b1;
    while (model_q.size() > 0) begin
      check("drain_valid", 32'(data_out_valid), 32'(1));
      check("drain_data", 32'(data_out), 32'(model_q.pop_front()));
      @(negedge clk);
    end
    data_out_ready = 1'b0;
    check("drain_count", 32'(fifo_count), 32'(0));
    check("drain_empty", 32'(data_out_valid), 32'(0));
  endtask

  initial begin
    logic [7:0] b;
    logic       stop_ok;
    int         glitch_len;

    rst = 1'b0;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", 32'(fifo_count), 32'(0));
    check("reset_valid", 32'(data_out_valid), 32'(0));
    check("reset_data", 32'(data_out), 32'(0));
    check("reset_ferr", 32'(frame_error), 32'(0));
    check("reset_ovf", 32'(overflow), 32'(0));
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Ready with an empty FIFO must not disturb anything
    data_out_ready = 1'b1;
    repeat (5) @(negedge clk);
    data_out_ready = 1'b0;
    check("ready_empty_count", 32'(fifo_count), 32'(0));

    // Single byte, with exact arrival timing
    send_byte(8'h61, 1'b1, 1'b0, 1'b1);
    check("first_data", 32'(data_out), 32'(8'h61));
    check("first_no_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("first_no_ovf", 32'(ovf_seen), 32'(exp_ovf));

    // Back-to-back burst into a FIFO that is never read
    for (int v = 'h62; v <= 'h6A; v++) begin
      b = 8'(v);
      send_byte(b, 1'b1, 1'b0, 1'b0);
    end
    check("burst_count", 32'(fifo_count), 32'(model_q.size()));
    check("burst_head", 32'(data_out), 32'(model_q[0]));
    check("burst_ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));

    // Full FIFO, pop coincides with the push of 0x7E
    send_byte(8'h7E, 1'b1, 1'b1, 1'b0);
    check("full_pushpop_count", 32'(fifo_count), 32'(DEPTH));
    check("full_pushpop_ovf", 32'(ovf_seen), 32'(exp_ovf));
    drain();

    // Start-bit glitch shorter than half a bit
    glitch_len = $urandom_range(20, 150);
    serial_in = 1'b0;
    repeat (glitch_len) @(negedge clk);
    serial_in = 1'b1;
    repeat (N) @(negedge clk);
    check("glitch_count", 32'(fifo_count), 32'(0));
    check("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("glitch_ovf", 32'(ovf_seen), 32'(exp_ovf));
    send_byte(8'h55, 1'b1, 1'b0, 1'b0);
    drain();

    // Framing error, then a clean frame
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    check("ferr_pulses", 32'(ferr_seen), 32'(exp_ferr));
    check("ferr_count", 32'(fifo_count), 32'(0));
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    check("after_ferr_data", 32'(data_out), 32'(8'h3C));

    // Reset in the middle of data bit 4, with 0x3C still buffered
    b = 8'($urandom);
    serial_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      serial_in = b[i];
      repeat ((i == 4) ? S : N) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("midreset_count", 32'(fifo_count), 32'(0));
    check("midreset_valid", 32'(data_out_valid), 32'(0));
    check("midreset_data", 32'(data_out), 32'(0));
    check("midreset_ferr", 32'(frame_error), 32'(0));
    check("midreset_ovf", 32'(overflow), 32'(0));
    model_q.delete();
    @(negedge clk);
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h42, 1'b1, 1'b0, 1'b0);
    drain();

    // Random frames, mostly with a good stop bit
    repeat (2) begin
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      send_byte(b, stop_ok, 1'b0, 1'b1);
    end
    check("rand_count", 32'(fifo_count), 32'(model_q.size()));
    drain();

    check("total_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("total_ovf", 32'(ovf_seen), 32'(exp_ovf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
